psum_bram_reader: RTL

- Read-side counterpart of the psum BRAM write port driven by dnn_accelerator_core (mem_addr_6/mem_idat_6/mem_wren_6).
- After a layer finishes, it reads a configured range of partial-sum words from the psum BRAM port and streams them out on a valid/ready interface toward the host/DMA path.
- Hides the 1-cycle BRAM read latency behind a 2-entry output FIFO and sustains 1 word/cycle under continuous ready.

---
 rtl/psum_bram_reader.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/psum_bram_reader.sv
// Streams a range of psum BRAM words out over valid/ready through a 2-entry FIFO.
// Optional: define PSUM_READER_RELU_EN to clamp negative words to zero at capture.
module psum_bram_reader #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 20,
  parameter int ADDR_STEP  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [LEN_WIDTH-1:0]  i_length,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_enb,
  input  logic [DATA_WIDTH-1:0] mem_odat,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_last,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int CW = LEN_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]         issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]         out_rem_q, out_rem_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            count_q, count_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;

  logic                  start_ok;
  logic                  pop;
  logic                  push;
  logic                  issue;
  logic [2:0]            occ_after;
  logic [DATA_WIDTH-1:0] cap_data;

`ifdef PSUM_READER_RELU_EN
  assign cap_data = mem_odat[DATA_WIDTH-1] ? '0 : mem_odat;
`else
  assign cap_data = mem_odat;
`endif

  assign o_valid  = (count_q != 2'd0);
  assign o_data   = head_q;
  assign o_last   = o_valid && (out_rem_q == CW'(1));
  assign o_busy   = (state_q == S_READ) || (state_q == S_DRAIN);
  assign o_done   = (state_q == S_DONE);
  assign pop      = o_valid && i_ready;
  assign push     = inflight_q;
  assign start_ok = (state_q == S_IDLE) && i_start && !i_abort;

  // Slots committed after this cycle: stored words plus the read still in flight.
  assign occ_after = 3'(count_q) + 3'(inflight_q) - 3'(pop);

  // The first read goes out in the start cycle so the first word is valid two cycles later.
  assign issue = !i_abort &&
                 (start_ok ||
                  ((state_q == S_READ) && (issue_cnt_q != '0) && (occ_after < 3'd2)));

  assign mem_enb  = issue;
  assign mem_addr = start_ok ? i_base_addr : addr_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    issue_cnt_d = issue_cnt_q;
    out_rem_d   = out_rem_q;
    inflight_d  = issue;
    count_d     = count_q;
    head_d      = head_q;
    tail_d      = tail_q;

    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = cap_data;
        else                 tail_d = cap_data;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = cap_data;
        end else begin
          head_d = tail_q;
          tail_d = cap_data;
        end
      end
      default: ;
    endcase

    if (pop) out_rem_d = out_rem_q - CW'(1);

    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          addr_d      = i_base_addr + ADDR_WIDTH'(ADDR_STEP);
          issue_cnt_d = CW'(i_length);
          out_rem_d   = CW'(i_length) + CW'(1);
          state_d     = S_READ;
        end
      end
      S_READ: begin
        if (issue) begin
          addr_d      = addr_q + ADDR_WIDTH'(ADDR_STEP);
          issue_cnt_d = issue_cnt_q - CW'(1);
        end
        if ((issue_cnt_q == '0) || (issue && (issue_cnt_q == CW'(1))))
          state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if ((out_rem_q == '0) || ((out_rem_q == CW'(1)) && pop))
          state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything, including a capture landing this cycle.
    if (i_abort) begin
      state_d     = S_IDLE;
      issue_cnt_d = '0;
      out_rem_d   = '0;
      inflight_d  = 1'b0;
      count_d     = 2'd0;
      head_d      = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      issue_cnt_q <= '0;
      out_rem_q   <= '0;
      inflight_q  <= 1'b0;
      count_q     <= 2'd0;
      head_q      <= '0;
      tail_q      <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      issue_cnt_q <= issue_cnt_d;
      out_rem_q   <= out_rem_d;
      inflight_q  <= inflight_d;
      count_q     <= count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
    end
  end

endmodule
